// File: rtl/sec_violation_unit.sv
// Security violation unit: turns store-guard crash pulses into a precise
// exception, counts accepted violations and locks the core after MAX_VIOL.
module sec_violation_unit #(
    parameter int unsigned VLEN     = 32,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_VIOL = 4,
    parameter logic [31:0] CAUSE    = 32'h18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             debug_mode_i,
    input  logic             flush_i,
    input  logic             to_crash_i,
    input  logic [VLEN-1:0]  pc_i,
    input  logic             ex_ack_i,
    output logic             ex_valid_o,
    output logic [31:0]      ex_cause_o,
    output logic [31:0]      ex_tval_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] viol_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [VLEN-1:0]  tval_q;
    logic             valid_q;
    logic             locked_q;
    logic             accept;
    logic             cnt_at_limit;

    assign accept = to_crash_i & ~flush_i & ~debug_mode_i & (state_q != LOCKED);

    // Saturating count; the lock decision looks at the value after this cycle's event.
    assign cnt_d        = (accept && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    assign cnt_at_limit = (64'(cnt_d) >= 64'(MAX_VIOL));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tval_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tval_q  <= pc_i;
                        state_q <= PENDING;
                        valid_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (ex_ack_i) begin
                        if (cnt_at_limit) begin
                            state_q  <= LOCKED;
                            valid_q  <= 1'b0;
                            locked_q <= 1'b1;
                        end else if (accept) begin
                            // Back-to-back exception: the new violation becomes the reported one.
                            tval_q <= pc_i;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    valid_q  <= 1'b0;
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    valid_q  <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_valid_o = valid_q;
    assign locked_o   = locked_q;
    assign viol_cnt_o = cnt_q;
    assign ex_cause_o = CAUSE;
    assign ex_tval_o  = 32'(tval_q);

endmodule

// File: tb/tb_sec_violation_unit.sv
// Directed bench for sec_violation_unit: expectations queued per step, checked one cycle later.
module tb_sec_violation_unit;

    typedef struct {
        int          id;
        logic        valid;
        logic [31:0] tval;
        logic [7:0]  cnt;
        logic        locked;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        dbg = 1'b0;
    logic        flush = 1'b0;
    logic        crash = 1'b0;
    logic [31:0] pc = '0;
    logic        ack = 1'b0;

    logic        valid1, locked1;
    logic [31:0] cause1, tval1;
    logic [7:0]  cnt1;
    logic        valid2, locked2;
    logic [31:0] cause2, tval2;
    logic [1:0]  cnt2;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    always #5 clk = ~clk;

    sec_violation_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .flush_i(flush),
        .to_crash_i(crash), .pc_i(pc), .ex_ack_i(ack),
        .ex_valid_o(valid1), .ex_cause_o(cause1), .ex_tval_o(tval1),
        .locked_o(locked1), .viol_cnt_o(cnt1)
    );

    sec_violation_unit #(.CNT_W(2), .MAX_VIOL(8)) dut_sat (
        .clk_i(clk), .rst_ni(rst2_n), .debug_mode_i(dbg), .flush_i(flush),
        .to_crash_i(crash), .pc_i(pc), .ex_ack_i(ack),
        .ex_valid_o(valid2), .ex_cause_o(cause2), .ex_tval_o(tval2),
        .locked_o(locked2), .viol_cnt_o(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then pop and compare after the edge.
    task automatic step(input logic c, input logic f, input logic d, input logic [31:0] p,
                        input logic a, input logic ev, input logic [31:0] et,
                        input logic [7:0] ec, input logic el);
        exp_t e;
        exp_t g;
        step_id++;
        e.id = step_id; e.valid = ev; e.tval = et; e.cnt = ec; e.locked = el;
        exp_q.push_back(e);
        crash = c; flush = f; dbg = d; pc = p; ack = a;
        @(posedge clk);
        #1;
        crash = 1'b0; flush = 1'b0; dbg = 1'b0; ack = 1'b0; pc = '0;
        g = exp_q.pop_front();
        $display("step %0d: crash=%0b flush=%0b dbg=%0b ack=%0b pc=%h -> valid=%0b tval=%h cnt=%0d locked=%0b",
                 g.id, c, f, d, a, p, valid1, tval1, cnt1, locked1);
        chk($sformatf("step%0d_valid", g.id), 32'(valid1), 32'(g.valid));
        chk($sformatf("step%0d_tval", g.id), tval1, g.tval);
        chk($sformatf("step%0d_cnt", g.id), 32'(cnt1), 32'(g.cnt));
        chk($sformatf("step%0d_locked", g.id), 32'(locked1), 32'(g.locked));
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(valid1), 32'd0);
        chk({tag, "_locked"}, 32'(locked1), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt1), 32'd0);
        chk({tag, "_tval"}, tval1, 32'd0);
        $display("async reset %s: valid=%0b locked=%0b cnt=%0d tval=%h", tag, valid1, locked1, cnt1, tval1);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_locked", 32'(locked1), 32'd0);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_tval", tval1, 32'd0);
        chk("rst_cause", cause1, 32'h18);
        rst_n = 1'b1;
        rst2_n = 1'b1;

        // Basic exception and ack, first edge after reset release
        step(1, 0, 0, 32'h80000200, 0, 1, 32'h80000200, 1, 0);
        chk("sat_first", 32'(cnt2), 32'd1);
        step(0, 0, 0, 32'h0, 1, 0, 32'h80000200, 1, 0);
        // Suppressed events and ack outside PENDING
        step(1, 1, 0, 32'h11110000, 0, 0, 32'h80000200, 1, 0);
        step(1, 0, 1, 32'h22220000, 0, 0, 32'h80000200, 1, 0);
        step(0, 0, 0, 32'h0, 1, 0, 32'h80000200, 1, 0);
        // First violation wins while pending; flush does not cancel PENDING
        step(1, 0, 0, 32'h80001000, 0, 1, 32'h80001000, 2, 0);
        step(1, 0, 0, 32'h80002000, 0, 1, 32'h80001000, 3, 0);
        chk("sat_three", 32'(cnt2), 32'd3);
        step(1, 1, 0, 32'h80003000, 0, 1, 32'h80001000, 3, 0);
        step(0, 0, 0, 32'h0, 0, 1, 32'h80001000, 3, 0);

        async_reset("rst_pending");

        // Same-cycle ack plus new violation, then run up to lock
        step(1, 0, 0, 32'h80000400, 0, 1, 32'h80000400, 1, 0);
        step(1, 0, 0, 32'h80000300, 1, 1, 32'h80000300, 2, 0);
        step(0, 0, 0, 32'h0, 1, 0, 32'h80000300, 2, 0);
        step(1, 0, 0, 32'h80000500, 0, 1, 32'h80000500, 3, 0);
        step(0, 0, 0, 32'h0, 1, 0, 32'h80000500, 3, 0);
        step(1, 0, 0, 32'h80000600, 0, 1, 32'h80000600, 4, 0);
        step(0, 0, 0, 32'h0, 1, 0, 32'h80000600, 4, 1);
        step(1, 0, 0, 32'h80000700, 0, 0, 32'h80000600, 4, 1);
        step(1, 0, 0, 32'h80000800, 1, 0, 32'h80000600, 4, 1);

        async_reset("rst_locked");

        // Four plain violation/ack rounds reach the lock on the fourth ack
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 32'h90000000 + 32'(i), 0, 1, 32'h90000000 + 32'(i), 8'(i), 0);
            step(0, 0, 0, 32'h0, 1, 0, 32'h90000000 + 32'(i), 8'(i), (i == 4) ? 1'b1 : 1'b0);
        end
        step(1, 0, 0, 32'hA0000000, 0, 0, 32'h90000004, 4, 1);
        step(0, 0, 0, 32'h0, 1, 0, 32'h90000004, 4, 1);

        chk("sat_final_cnt", 32'(cnt2), 32'd3);
        chk("sat_final_locked", 32'(locked2), 32'd0);
        chk("sat_cause", cause2, 32'h18);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
